// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer's switch/key MMIO input path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sc_io_pkg;

    localparam logic [31:0] SW_ADDR  = 32'hffffff00;
    localparam logic [31:0] KEY_ADDR = 32'hffffff10;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

    // Synchroniser reset levels in raw pin polarity: switches off, keys released.
    localparam logic SW_SYNC_RESET  = 1'b0;
    localparam logic KEY_SYNC_RESET = 1'b1;

    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/sc_io_debounce_if.sv
// Pin/MMIO-side bundle of the switch/key conditioning stage.
// Latency: n/a (wires only).
// Backpressure: none; levels and sticky flags only.
interface sc_io_debounce_if #(
    parameter int N_SW  = 10,
    parameter int N_KEY = 4
);
    logic [N_SW-1:0]  sw_raw;
    logic [N_KEY-1:0] key_raw;
    logic             key_clr;
    logic [N_SW-1:0]  sw_out;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_event;
    logic             irq;

    // Pins and MMIO decoder side.
    modport master (
        output sw_raw, key_raw, key_clr,
        input  sw_out, key_level, key_event, irq
    );

    // Conditioning stage side.
    modport slave (
        input  sw_raw, key_raw, key_clr,
        output sw_out, key_level, key_event, irq
    );
endinterface

// File: rtl/sc_debounce_bit.sv
// One input bit: 2-flop synchroniser, run-length counter, debounced level register.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a stable raw change to level.
// Backpressure: none.
module sc_debounce_bit
    import sc_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter logic INVERT          = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int             CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_nxt;
    logic          samp;

    assign samp = sync[1] ^ INVERT;

    always_comb begin
        cnt_nxt   = '0;
        level_nxt = level;
        if (samp != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = samp;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // Rising edge of the debounced level, visible the cycle before it registers.
    assign rise = level_nxt & ~level;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= {2{RESET_LEVEL}};
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end
endmodule

// File: rtl/sc_io_debounce.sv
// Debounced switch levels and sticky key-press flags for the switch/key MMIO registers.
// Latency: 2 + DEBOUNCE_CYCLES to levels; key_event sets with key_level; irq one cycle later.
// Backpressure: none; key_clr clears flags, a same-cycle press wins. Option: SC_IO_DEBOUNCE_IRQ_EN.
module sc_io_debounce
    import sc_io_pkg::*;
#(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    sc_io_debounce_if.slave io
);
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_rise_unused;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_rise;
    logic [N_KEY-1:0] key_event_q;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        sc_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (SW_SYNC_RESET),
            .INVERT          (1'b0)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .raw   (io.sw_raw[i]),
            .level (sw_level[i]),
            .rise  (sw_rise_unused[i])
        );
    end

    // Keys are active-low at the pin; the debounced level is active-high.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        sc_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (KEY_SYNC_RESET),
            .INVERT          (1'b1)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .raw   (io.key_raw[i]),
            .level (key_level[i]),
            .rise  (key_rise[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_event_q <= '0;
        end else begin
            key_event_q <= (io.key_clr ? '0 : key_event_q) | key_rise;
        end
    end

    assign io.sw_out    = sw_level;
    assign io.key_level = key_level;
    assign io.key_event = key_event_q;

`ifdef SC_IO_DEBOUNCE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |key_event_q;
        end
    end

    assign io.irq = irq_q;
`else
    assign io.irq = 1'b0;
`endif
endmodule

// File: tb/tb_sc_io_debounce.sv
// Directed test-plan sequences followed by random pin activity, checked against a window-based model.
module tb_sc_io_debounce;
    import sc_io_pkg::*;

    localparam int N_SW  = 10;
    localparam int N_KEY = 4;
    localparam int DC    = 4;
`ifdef SC_IO_DEBOUNCE_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    sc_io_debounce_if #(.N_SW(N_SW), .N_KEY(N_KEY)) io ();

    sc_io_debounce #(
        .N_SW            (N_SW),
        .N_KEY           (N_KEY),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: {keys, switches}; synchroniser flops kept in raw pin polarity.
    logic [13:0] m_s1, m_s2;
    logic [13:0] m_win[$];
    logic [9:0]  m_sw;
    logic [3:0]  m_kl, m_ke;
    logic        m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A debounced bit flips once its last DC post-reset samples all disagree with it.
    task automatic model_edge();
        logic [13:0] samp, old_deb, new_deb;
        logic        stable;
        if (reset) begin
            m_s1 = {4'hF, 10'h000};
            m_s2 = {4'hF, 10'h000};
            m_win.delete();
            m_sw = '0; m_kl = '0; m_ke = '0; m_irq = 1'b0;
        end else begin
            samp = {~m_s2[13:10], m_s2[9:0]};
            m_win.push_back(samp);
            if (m_win.size() > DC) void'(m_win.pop_front());
            old_deb = {m_kl, m_sw};
            new_deb = old_deb;
            if (m_win.size() == DC) begin
                for (int b = 0; b < 14; b++) begin
                    stable = 1'b1;
                    foreach (m_win[j]) if (m_win[j][b] == old_deb[b]) stable = 1'b0;
                    if (stable) new_deb[b] = ~old_deb[b];
                end
            end
            m_irq = IRQ_EN & (|m_ke);
            m_ke  = (io.key_clr ? 4'h0 : m_ke) | (new_deb[13:10] & ~old_deb[13:10]);
            m_s2  = m_s1;
            m_s1  = {io.key_raw, io.sw_raw};
            m_sw  = new_deb[9:0];
            m_kl  = new_deb[13:10];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("sw_out",    32'(io.sw_out),    32'(m_sw));
        chk("key_level", 32'(io.key_level), 32'(m_kl));
        chk("key_event", 32'(io.key_event), 32'(m_ke));
        chk("irq",       32'(io.irq),       32'(m_irq));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset      = 1'b1;
        io.sw_raw  = 10'h3FF;
        io.key_raw = 4'h0;
        io.key_clr = 1'b0;

        // Reset, then pressed keys and set switches emerge 6 cycles after release.
        repeat (2) begin
            tick();
            chk("rst_sw", 32'(io.sw_out), 0);
            chk("rst_ke", 32'(io.key_event), 0);
            chk("rst_irq", 32'(io.irq), 0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_sw", 32'(io.sw_out), 0);
        chk("post_rst_kl", 32'(io.key_level), 0);
        repeat (4) tick();
        chk("rst_sw_t5", 32'(io.sw_out), 0);
        tick();
        chk("rst_sw_t6", 32'(io.sw_out), 32'h3FF);
        chk("rst_kl_t6", 32'(io.key_level), 32'hF);
        chk("rst_ke_t6", 32'(io.key_event), 32'hF);

        // Switch latency.
        io.sw_raw = 10'h000;
        repeat (8) tick();
        io.sw_raw = 10'h155;
        repeat (5) tick();
        chk("sw_lat_t5", 32'(io.sw_out), 0);
        tick();
        chk("sw_lat_t6", 32'(io.sw_out), 32'h155);

        // Release keys and clear pending events.
        io.key_raw = 4'hF;
        repeat (8) tick();
        io.key_clr = 1'b1;
        tick();
        io.key_clr = 1'b0;
        tick();
        chk("rel_ke", 32'(io.key_event), 0);
        chk("rel_kl", 32'(io.key_level), 0);

        // Glitch of 3 cycles is rejected.
        io.key_raw = 4'hE;
        repeat (3) tick();
        io.key_raw = 4'hF;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("glitch_kl", 32'(io.key_level), 0);
            chk("glitch_ke", 32'(io.key_event), 0);
        end

        // Press, clear, release.
        io.key_raw = 4'b1101;
        repeat (5) tick();
        chk("press_kl_t5", 32'(io.key_level), 0);
        tick();
        chk("press_kl_t6", 32'(io.key_level), 32'h2);
        chk("press_ke_t6", 32'(io.key_event), 32'h2);
        chk("press_irq_t6", 32'(io.irq), 0);
        tick();
        chk("press_irq_t7", 32'(io.irq), 32'(IRQ_EN));
        tick();
        io.key_clr = 1'b1;
        tick();
        io.key_clr = 1'b0;
        chk("clr_ke_t9", 32'(io.key_event), 0);
        chk("clr_kl_t9", 32'(io.key_level), 32'h2);
        chk("clr_irq_t9", 32'(io.irq), 32'(IRQ_EN));
        tick();
        chk("clr_irq_t10", 32'(io.irq), 0);
        io.key_raw = 4'hF;
        repeat (10) tick();
        chk("release_ke", 32'(io.key_event), 0);
        chk("release_kl", 32'(io.key_level), 0);

        // Set wins over a simultaneous clear.
        io.key_raw = 4'b1110;
        repeat (6) tick();
        chk("sim_ke_pend", 32'(io.key_event), 32'h1);
        io.key_raw = 4'b0110;
        repeat (5) tick();
        io.key_clr = 1'b1;
        tick();
        io.key_clr = 1'b0;
        chk("sim_ke", 32'(io.key_event), 32'h8);
        chk("sim_kl", 32'(io.key_level), 32'h9);

        // Random pin activity with occasional clears and mid-run resets.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            io.sw_raw  = io.sw_raw ^ 10'($urandom & $urandom & $urandom);
            io.key_raw = io.key_raw ^ 4'($urandom & $urandom & $urandom);
            io.key_clr = ($urandom_range(0, 9) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
